booth_r4_seq_mult: RTL

Sequential signed radix-4 Booth multiplier controller. It accepts one operand pair over a valid/ready handshake and walks the multiplier one Booth digit per cycle. Each cycle it drives a single shared partial-product row generator and accumulates the shifted row into a double-width product register. It is the compact, area-optimised multiply engine for the DNN MAC path. It can optionally truncate low-order partial-product columns for approximate multiplication.

---
 rtl/booth_r4_pkg.sv | 21 ++
 rtl/booth_r4_pp_row.sv | 32 +++
 rtl/booth_r4_seq_mult.sv | 122 ++++++++++++
 3 files changed

// File: rtl/booth_r4_pkg.sv
// booth_r4_pkg: shared types for the radix-4 Booth sequential multiplier.
//   state_t       : controller FSM states
//   booth_digit_t : recoded Booth digit driven into the row generator
//   booth_decode  : 3-bit multiplier window {b[2i+1], b[2i], b[2i-1]} -> digit
package booth_r4_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} booth_digit_t;

  function automatic booth_digit_t booth_decode(input logic [2:0] win);
    case (win)
      3'b001, 3'b010: return POS1;
      3'b011:         return POS2;
      3'b100:         return NEG2;
      3'b101, 3'b110: return NEG1;
      default:        return ZERO;  // 000 and 111
    endcase
  endfunction

endpackage

// File: rtl/booth_r4_pp_row.sv
// booth_r4_pp_row: combinational radix-4 Booth partial-product row.
//   a     : multiplicand, signed two's complement, WIDTH bits
//   digit : Booth digit in {-2,-1,0,+1,+2}
//   row   : digit*a, signed, WIDTH+2 bits (enough for -2 * -2^(WIDTH-1))
module booth_r4_pp_row
  import booth_r4_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  booth_digit_t     digit,
  output logic [WIDTH+1:0] row
);

  logic [WIDTH+1:0] ax, ax2;

  assign ax  = {{2{a[WIDTH-1]}}, a};
  assign ax2 = {ax[WIDTH:0], 1'b0};

  // Negation is taken on the sign-extended value so -(-2^(W-1)) is exact.
  always_comb begin
    row = '0;
    case (digit)
      POS1:    row = ax;
      POS2:    row = ax2;
      NEG1:    row = ~ax + (WIDTH+2)'(1);
      NEG2:    row = ~ax2 + (WIDTH+2)'(1);
      default: row = '0;
    endcase
  end

endmodule

// File: rtl/booth_r4_seq_mult.sv
// booth_r4_seq_mult: sequential signed radix-4 Booth multiplier.
// One Booth digit per cycle through a single shared row generator; the
// shifted row is registered once before accumulation, so RUN lasts
// WIDTH/2+1 cycles (the last one drains the final row into prod_out).
//   clk, rst            : clock, async active-high reset
//   in_valid/in_ready   : operand handshake (a_in, b_in sampled on accept)
//   out_valid/out_ready : product handshake, prod_out registered
// Build option: define APPROX_LSB_TRUNC_EN to zero the low TRUNC_COLS
// columns of every shifted row (approximate product, no compensation).
module booth_r4_seq_mult
  import booth_r4_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int TRUNC_COLS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] prod_out
);

  localparam int PW = 2 * WIDTH;
  localparam int ND = WIDTH / 2;
  localparam int CW = (ND > 1) ? $clog2(ND) : 1;

`ifdef APPROX_LSB_TRUNC_EN
  localparam int TRUNC_EN = 1;
`else
  localparam int TRUNC_EN = 0;
`endif
  localparam int            TC         = TRUNC_COLS * TRUNC_EN;
  localparam logic [PW-1:0] TRUNC_MASK = {PW{1'b1}} << TC;

  state_t          state, nstate;
  logic [CW-1:0]   cnt;
  logic            drain;
  logic [WIDTH-1:0] a_r, b_r;
  logic [PW-1:0]   acc, row_q;

  logic [WIDTH:0]   bext;
  logic [2:0]       win;
  booth_digit_t     digit;
  logic [WIDTH+1:0] row;
  logic [PW-1:0]    row_ext, row_sh;

  // Row generation for digit cnt; b[-1] = 0 comes from the appended zero.
  assign bext    = {b_r, 1'b0};
  assign win     = bext[{cnt, 1'b0} +: 3];
  assign digit   = booth_decode(win);
  assign row_ext = {{(PW-WIDTH-2){row[WIDTH+1]}}, row};
  assign row_sh  = (row_ext << {cnt, 1'b0}) & TRUNC_MASK;

  booth_r4_pp_row #(.WIDTH(WIDTH)) u_row (
    .a     (a_r),
    .digit (digit),
    .row   (row)
  );

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  // FSM: next state
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (in_valid) nstate = RUN;
      RUN:     if (drain) nstate = DONE;
      DONE:    if (out_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // FSM: outputs, state-only
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r      <= '0;
      b_r      <= '0;
      acc      <= '0;
      row_q    <= '0;
      cnt      <= '0;
      drain    <= 1'b0;
      prod_out <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r   <= a_in;
          b_r   <= b_in;
          acc   <= '0;
          row_q <= '0;
          cnt   <= '0;
          drain <= 1'b0;
        end
        RUN: begin
          acc <= acc + row_q;
          if (drain) begin
            prod_out <= acc + row_q;
          end else begin
            row_q <= row_sh;
            if (cnt == CW'(ND-1)) drain <= 1'b1;
            else                  cnt   <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
